// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial_deser framer.
// Optional parity feature: SERIAL_DESER_PARITY_EN.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StLock,
    StPar
  } state_e;

  localparam int unsigned DefWidth    = 8;
  localparam logic [31:0] DefSync     = 32'h0000_00A5;
  localparam int unsigned DefFrameLen = 4;

  // Even parity holds when the word and its parity bit XOR to zero.
  function automatic logic even_parity_ok(input logic [31:0] word, input logic pbit);
    return ~((^word) ^ pbit);
  endfunction

endpackage

// File: rtl/serial_deser_obuf.sv
// One-entry valid/ready output register for serial_deser.
// A push while full without a same-cycle pop drops the word and sets a sticky overrun.
module serial_deser_obuf
  import serial_deser_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  output logic             overrun_o
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             pop;

  // Next-state: push wins over pop; a full buffer only accepts when it drains in the same cycle.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    pop       = valid_q & out_ready_i;
    if (push_i) begin
      if (!valid_q || out_ready_i) begin
        data_d  = push_data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel framer: hunts for SYNC, then assembles FRAME_LEN words per frame.
// Optional even-parity bit after each payload word: SERIAL_DESER_PARITY_EN.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefWidth,
  parameter logic [WIDTH-1:0] SYNC      = DefSync[WIDTH-1:0],
  parameter int unsigned      FRAME_LEN = DefFrameLen
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync_lock,
  output logic             overrun,
  output logic             parity_err
);

  localparam logic [5:0] HuntLast  = 6'(WIDTH - 1);
  localparam logic [4:0] BitLast   = 5'(WIDTH - 1);
  localparam logic [7:0] WordLast  = 8'(FRAME_LEN - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [5:0]       hunt_cnt_q;
  logic [4:0]       bit_cnt_q;
  logic [7:0]       word_cnt_q;

  logic [WIDTH-1:0] sr_next;
  logic             push;
  logic [WIDTH-1:0] push_data;

`ifdef SERIAL_DESER_PARITY_EN
  logic par_ok;
  logic parity_err_q;

  // Word is held in sr while the parity bit arrives; commit only on good parity.
  always_comb begin
    sr_next   = {sr_q[WIDTH-2:0], d};
    par_ok    = even_parity_ok(32'(sr_q), d);
    push      = en && (state_q == StPar) && par_ok;
    push_data = sr_q;
  end

  assign parity_err = parity_err_q;
`else
  // The updated sr is the complete word on the last data bit.
  always_comb begin
    sr_next   = {sr_q[WIDTH-2:0], d};
    push      = en && (state_q == StLock) && (bit_cnt_q == BitLast);
    push_data = sr_next;
  end

  assign parity_err = 1'b0;
`endif

  // Bit-side state: shift register, counters and framing FSM; everything holds when en=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      sr_q       <= '0;
      hunt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
`ifdef SERIAL_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
`ifdef SERIAL_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (en) begin
        sr_q <= sr_next;
        unique case (state_q)
          StHunt: begin
            if (hunt_cnt_q <= HuntLast) hunt_cnt_q <= hunt_cnt_q + 6'd1;
            // Require WIDTH fresh bits so stale sr contents cannot match.
            if ((hunt_cnt_q >= HuntLast) && (sr_next == SYNC)) begin
              state_q    <= StLock;
              bit_cnt_q  <= '0;
              word_cnt_q <= '0;
            end
          end
          StLock: begin
            if (bit_cnt_q == BitLast) begin
`ifdef SERIAL_DESER_PARITY_EN
              state_q <= StPar;
`else
              if (word_cnt_q == WordLast) begin
                state_q    <= StHunt;
                hunt_cnt_q <= '0;
              end else begin
                word_cnt_q <= word_cnt_q + 8'd1;
                bit_cnt_q  <= '0;
              end
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
`ifdef SERIAL_DESER_PARITY_EN
          StPar: begin
            if (par_ok) begin
              if (word_cnt_q == WordLast) begin
                state_q    <= StHunt;
                hunt_cnt_q <= '0;
              end else begin
                state_q    <= StLock;
                word_cnt_q <= word_cnt_q + 8'd1;
                bit_cnt_q  <= '0;
              end
            end else begin
              parity_err_q <= 1'b1;
              state_q      <= StHunt;
              hunt_cnt_q   <= '0;
            end
          end
`endif
          default: begin
            state_q    <= StHunt;
            hunt_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign sync_lock = (state_q != StHunt);

  serial_deser_obuf #(
    .Width(WIDTH)
  ) u_obuf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .overrun_o   (overrun)
  );

endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-to-parallel framer consuming the 1-bit stream from the DFF shift chain (`q` output). It hunts for a sync word, assembles a fixed number of WIDTH-bit payload words per frame, and presents each word on a valid/ready output. A one-entry output register decouples the bit stream from the consumer, and output-side stalls are reported as overrun.

## Interface
- WIDTH, 8: bits per sync word and per payload word; must be 2 to 32.
- SYNC, 8'hA5: sync pattern, WIDTH bits, compared MSB-first.
- FRAME_LEN, 4: payload words per frame; must be 1 to 255.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- d  in  1  serial bit, sampled when en=1.
- en  in  1  bit qualifier; en=0 freezes all bit-side state.
- out_data  out  WIDTH  assembled word; MSB is the first-received bit.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid=1.
- sync_lock  out  1  1 while the FSM is in LOCK (or PAR).
- overrun  out  1  sticky; set when a completed word is dropped. Cleared only by reset.
- parity_err  out  1  one-cycle pulse on a parity mismatch. Tied 0 when the parity feature is compiled out.

## Operation
- Shift register sr, WIDTH bits: sr <= {sr[WIDTH-2:0], d} on every en=1 cycle, in all states.
- States:
  - HUNT:
    - hunt_cnt saturates at WIDTH and is cleared on entry to HUNT.
    - When hunt_cnt reaches WIDTH and the updated sr equals SYNC: go to LOCK, clear bit_cnt and word_cnt.
    - The hunt_cnt condition prevents a false match on cleared sr contents.
  - LOCK:
    - bit_cnt counts 0 to WIDTH-1.
    - On the bit that makes bit_cnt=WIDTH-1, the updated sr is a complete word.
    - With SERIAL_DESER_PARITY_EN defined, go to PAR. Otherwise commit the word.
  - PAR (parity builds only):
    - The next en bit is the parity bit. Even parity is required: XOR of word and parity bit = 0.
    - On a match, commit the word. On a mismatch, drop the word, pulse parity_err and go to HUNT.
- Commit:
  - The word is written to the output register if out_valid=0, or if out_valid=1 and out_ready=1 in the same cycle (simultaneous pop and push, no overrun).
  - Otherwise the word is dropped, overrun is set, and the existing out_data is kept unchanged.
  - word_cnt increments on every completed word, whether written or dropped.
  - When word_cnt reaches FRAME_LEN: go to HUNT and clear hunt_cnt. Otherwise return to LOCK with bit_cnt=0.
- Output handshake:
  - A transfer occurs on a cycle with out_valid=1 and out_ready=1.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid deasserts the cycle after a transfer unless a new word is written in that same cycle.
- en=0: sr, counters and FSM hold. The output handshake still operates.

## Timing
- Reset values: out_data=0, out_valid=0, sync_lock=0, overrun=0, parity_err=0. Internal state after reset: FSM=HUNT, sr=0, all counters 0.
- Reset asserted mid-frame: the partial word and any buffered word are discarded, and the output register is cleared, on the next clk edge.
- Sync lock: sync_lock rises the cycle after the final sync bit is sampled.
- Word latency: out_valid rises the cycle after the last word bit is sampled (the parity bit when parity is enabled).
- Throughput: one word per WIDTH en-cycles, or WIDTH+1 with parity. The consumer has at least WIDTH-1 cycles to drain before an overrun occurs.
- parity_err is asserted in the cycle following the parity bit sample.
- Back-to-back frames: a new sync word is accepted only after WIDTH fresh bits have been shifted in HUNT; there is no overlap with the previous frame's last word.

## Configuration
- SERIAL_DESER_PARITY_EN:
  - Defined: each payload word is followed by one even-parity bit, the PAR state exists, and parity_err is live.
  - Undefined: no parity bit, PAR is absent, parity_err is constant 0.
  - The sync word never carries parity in either configuration.

## Structure
- Package serial_deser_pkg holds:
  - the state enum typedef: HUNT, LOCK, PAR;
  - the default-width constants;
  - the parity helper function.
- Sub-module serial_deser_obuf: the one-entry valid/ready output register, with push/push_data/full-drop semantics and the overrun flag.
- The top level contains sr, the counters and the FSM.

## Test plan
- Reset, then a bit stream of A5 followed by 4 words 12,34,56,78, with out_ready=1 → four out_valid pulses carrying 12,34,56,78 in order. After the frame: sync_lock=0 and overrun=0.
- Stream 5A, then 2D (no A5 alignment) → no lock and out_valid stays 0. Then A5 followed by words → lock one cycle after the last sync bit.
- Hold out_ready=0 for two full words → the first word is held stable, the second is dropped and overrun=1. Raise out_ready → the first word transfers and overrun remains 1.
- Set out_ready=1 only on the cycle a new word commits while full → the old word transfers, the new word is loaded, overrun stays 0.
- Parity build: send word 0x12 followed by parity bit 1 (wrong) → parity_err pulses once, no output, FSM returns to HUNT. Then a correct frame is received normally.
- Assert rst_n=0 for one cycle mid-word with en toggling → all outputs are 0. The previous partial word never appears, and relock requires a fresh A5.
